reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 150 +++++++++++++++
 tb/tb_reset_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staggered reset release for the core: holds every domain in reset, releases them one by one,
// then counts run cycles against a limit. hit_reset restarts the sequence at run time.
module reset_sequencer #(
    parameter int unsigned NUM_DOMAINS    = 2,
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned STAGGER_CYCLES = 2,
    parameter int unsigned RUN_LIMIT      = 4800,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hit_reset,
    output logic [NUM_DOMAINS-1:0] domain_reset_n,
    output logic                   all_released,
    output logic [CNT_W-1:0]       run_cycles,
    output logic                   run_done,
    output logic [7:0]             reset_count
);

    localparam int unsigned HOLD_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int unsigned HW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam int unsigned DW       = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [HW-1:0]    HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]    STAG_LAST  = HW'(STAGGER_CYCLES - 1);
    localparam logic [DW-1:0]    DOM_LAST   = DW'(NUM_DOMAINS - 1);
    localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'((RUN_LIMIT == 0) ? 0 : RUN_LIMIT - 1);
    localparam bit               LIMIT_EN   = (RUN_LIMIT != 0);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic [DW-1:0]          dom_idx_q, dom_idx_d;
    logic [NUM_DOMAINS-1:0] dom_n_q, dom_n_d;
    logic                   all_rel_q, all_rel_d;
    logic [CNT_W-1:0]       run_cycles_q, run_cycles_d;
    logic                   run_done_q, run_done_d;
    logic [7:0]             reset_count_q, reset_count_d;
    logic [NUM_DOMAINS-1:0] release_mask;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        dom_idx_d     = dom_idx_q;
        dom_n_d       = dom_n_q;
        all_rel_d     = all_rel_q;
        run_cycles_d  = run_cycles_q;
        run_done_d    = run_done_q;
        reset_count_d = reset_count_q;

        release_mask = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            release_mask[i] = (dom_idx_q == DW'(i));
        end

        if (hit_reset) begin
            // A held request only counts on the edge that leaves a released state.
            state_d      = ST_ASSERT;
            hold_cnt_d   = '0;
            dom_n_d      = '0;
            all_rel_d    = 1'b0;
            run_cycles_d = '0;
            run_done_d   = 1'b0;
            if (state_q != ST_ASSERT && reset_count_q != 8'hFF) begin
                reset_count_d = reset_count_q + 8'd1;
            end
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (hold_cnt_q != HOLD_LAST) begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end else begin
                        dom_n_d[0] = 1'b1;
                        if (NUM_DOMAINS == 1) begin
                            state_d   = ST_RUN;
                            all_rel_d = 1'b1;
                        end else begin
                            state_d    = ST_RELEASE;
                            dom_idx_d  = DW'(1);
                            hold_cnt_d = '0;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (hold_cnt_q != STAG_LAST) begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end else begin
                        hold_cnt_d = '0;
                        dom_n_d    = dom_n_q | release_mask;
                        if (dom_idx_q == DOM_LAST) begin
                            state_d   = ST_RUN;
                            all_rel_d = 1'b1;
                        end else begin
                            dom_idx_d = dom_idx_q + DW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    run_cycles_d = run_cycles_q + CNT_W'(1);
                    if (LIMIT_EN && run_cycles_q == LIMIT_LAST) begin
                        run_done_d = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_ASSERT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ASSERT;
            hold_cnt_q    <= '0;
            dom_idx_q     <= '0;
            dom_n_q       <= '0;
            all_rel_q     <= 1'b0;
            run_cycles_q  <= '0;
            run_done_q    <= 1'b0;
            reset_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            dom_idx_q     <= dom_idx_d;
            dom_n_q       <= dom_n_d;
            all_rel_q     <= all_rel_d;
            run_cycles_q  <= run_cycles_d;
            run_done_q    <= run_done_d;
            reset_count_q <= reset_count_d;
        end
    end

    assign domain_reset_n = dom_n_q;
    assign all_released   = all_rel_q;
    assign run_cycles     = run_cycles_q;
    assign run_done       = run_done_q;
    assign reset_count    = reset_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three parameter sets share reset/hit_reset and are checked every cycle
// against a model that derives outputs from the number of quiet edges since the last reset or request.
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic hit_reset;

    logic [1:0]  dom_a;
    logic        all_a;
    logic [31:0] run_a;
    logic        done_a;
    logic [7:0]  rc_a;

    logic [0:0]  dom_b;
    logic        all_b;
    logic [31:0] run_b;
    logic        done_b;
    logic [7:0]  rc_b;

    logic [2:0]  dom_c;
    logic        all_c;
    logic [31:0] run_c;
    logic        done_c;
    logic [7:0]  rc_c;

    reset_sequencer #(.NUM_DOMAINS(2), .HOLD_CYCLES(4), .STAGGER_CYCLES(2), .RUN_LIMIT(8), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .hit_reset(hit_reset),
        .domain_reset_n(dom_a), .all_released(all_a), .run_cycles(run_a),
        .run_done(done_a), .reset_count(rc_a)
    );

    reset_sequencer #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(2), .RUN_LIMIT(8), .CNT_W(32)) dut_b (
        .clk(clk), .reset(reset), .hit_reset(hit_reset),
        .domain_reset_n(dom_b), .all_released(all_b), .run_cycles(run_b),
        .run_done(done_b), .reset_count(rc_b)
    );

    reset_sequencer #(.NUM_DOMAINS(3), .HOLD_CYCLES(3), .STAGGER_CYCLES(1), .RUN_LIMIT(0), .CNT_W(32)) dut_c (
        .clk(clk), .reset(reset), .hit_reset(hit_reset),
        .domain_reset_n(dom_c), .all_released(all_c), .run_cycles(run_c),
        .run_done(done_c), .reset_count(rc_c)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int n_t[3]  = '{2, 1, 3};
    int h_t[3]  = '{4, 1, 3};
    int s_t[3]  = '{2, 2, 1};
    int rl_t[3] = '{8, 8, 0};
    int age[3]  = '{0, 0, 0};
    int rc[3]   = '{0, 0, 0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic int last_rel(int k);
        return h_t[k] + (n_t[k] - 1) * s_t[k];
    endfunction

    function automatic logic [15:0] exp_dom(int k);
        logic [15:0] d = '0;
        for (int i = 0; i < n_t[k]; i++) begin
            if (age[k] >= h_t[k] + i * s_t[k]) d[i] = 1'b1;
        end
        return d;
    endfunction

    function automatic int exp_run(int k);
        int r = (age[k] > last_rel(k)) ? age[k] - last_rel(k) : 0;
        if (rl_t[k] != 0 && r > rl_t[k]) r = rl_t[k];
        return r;
    endfunction

    function automatic logic exp_done(int k);
        return (rl_t[k] != 0) && (exp_run(k) >= rl_t[k]);
    endfunction

    // Model update for one edge, from the inputs sampled on that edge.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                age[k] = 0;
                rc[k]  = 0;
            end else if (hit_reset) begin
                if (age[k] >= h_t[k] && rc[k] < 255) rc[k]++;
                age[k] = 0;
            end else if (age[k] < 100000) begin
                age[k]++;
            end
        end
    endtask

    task automatic check_all();
        check("a_dom",  64'(dom_a),  64'(exp_dom(0)));
        check("a_all",  64'(all_a),  64'(age[0] >= last_rel(0)));
        check("a_run",  64'(run_a),  64'(exp_run(0)));
        check("a_done", 64'(done_a), 64'(exp_done(0)));
        check("a_rc",   64'(rc_a),   64'(rc[0]));
        check("b_dom",  64'(dom_b),  64'(exp_dom(1)));
        check("b_all",  64'(all_b),  64'(age[1] >= last_rel(1)));
        check("b_run",  64'(run_b),  64'(exp_run(1)));
        check("b_done", 64'(done_b), 64'(exp_done(1)));
        check("b_rc",   64'(rc_b),   64'(rc[1]));
        check("c_dom",  64'(dom_c),  64'(exp_dom(2)));
        check("c_all",  64'(all_c),  64'(age[2] >= last_rel(2)));
        check("c_run",  64'(run_c),  64'(exp_run(2)));
        check("c_done", 64'(done_c), 64'(exp_done(2)));
        check("c_rc",   64'(rc_c),   64'(rc[2]));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input logic r, input logic h);
        reset     = r;
        hit_reset = h;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        hit_reset = 1'b0;
        @(negedge clk);

        // Master reset, then the default release sequence.
        repeat (3) tick(1'b1, 1'b0);
        check("a_dom_reset", 64'(dom_a), 64'(2'b00));
        check("a_rc_reset",  64'(rc_a),  64'(8'd0));
        for (int e = 0; e < 6; e++) begin
            tick(1'b0, 1'b0);
            if (e == 0) begin
                check("b_dom_e0", 64'(dom_b), 64'(1'b1));
                check("b_all_e0", 64'(all_b), 64'(1'b1));
            end
            if (e == 2) check("a_dom_e2", 64'(dom_a), 64'(2'b00));
            if (e == 3) check("a_dom_e3", 64'(dom_a), 64'(2'b01));
            if (e == 4) check("a_all_e4", 64'(all_a), 64'(1'b0));
            if (e == 5) begin
                check("a_dom_e5", 64'(dom_a), 64'(2'b11));
                check("a_all_e5", 64'(all_a), 64'(1'b1));
            end
        end
        for (int e = 6; e < 11; e++) begin
            tick(1'b0, 1'b0);
            if (e == 6) check("a_run_e6", 64'(run_a), 64'(32'd1));
        end
        check("a_run_5", 64'(run_a), 64'(32'd5));

        // One-cycle request in RUN, then the replayed release.
        tick(1'b0, 1'b1);
        check("a_dom_hit", 64'(dom_a), 64'(2'b00));
        check("a_run_hit", 64'(run_a), 64'(32'd0));
        check("a_rc_hit",  64'(rc_a),  64'(8'd1));
        for (int e = 0; e < 6; e++) begin
            tick(1'b0, 1'b0);
            if (e == 3) check("a_dom_rel0", 64'(dom_a), 64'(2'b01));
            if (e == 5) check("a_dom_rel1", 64'(dom_a), 64'(2'b11));
        end
        for (int e = 0; e < 8; e++) begin
            tick(1'b0, 1'b0);
            if (e == 6) check("a_done_early", 64'(done_a), 64'(1'b0));
        end
        check("a_done_lim", 64'(done_a), 64'(1'b1));
        check("a_run_lim",  64'(run_a),  64'(32'd8));
        repeat (3) tick(1'b0, 1'b0);
        check("a_run_frozen", 64'(run_a), 64'(32'd8));

        // Request during DONE replays the whole sequence.
        tick(1'b0, 1'b1);
        check("a_done_clr", 64'(done_a), 64'(1'b0));
        check("a_rc_done",  64'(rc_a),   64'(8'd2));
        for (int e = 0; e < 14; e++) begin
            tick(1'b0, 1'b0);
            if (e == 12) check("a_done_replay_early", 64'(done_a), 64'(1'b0));
        end
        check("a_done_replay", 64'(done_a), 64'(1'b1));

        // Held request: domains stay low, counted once, hold restarts after release of the request.
        for (int e = 0; e < 10; e++) begin
            tick(1'b0, 1'b1);
            check("a_dom_held", 64'(dom_a), 64'(2'b00));
        end
        check("a_rc_held", 64'(rc_a), 64'(8'd3));
        for (int e = 0; e < 4; e++) begin
            tick(1'b0, 1'b0);
            if (e == 2) check("a_dom_held_e2", 64'(dom_a), 64'(2'b00));
        end
        check("a_dom_held_e3", 64'(dom_a), 64'(2'b01));

        // Master reset mid-release, and reset together with a request.
        tick(1'b1, 1'b0);
        check("a_dom_mreset", 64'(dom_a), 64'(2'b00));
        check("a_rc_mreset",  64'(rc_a),  64'(8'd0));
        repeat (2) tick(1'b1, 1'b1);
        check("a_rc_both", 64'(rc_a), 64'(8'd0));
        tick(1'b0, 1'b1);
        check("a_rc_in_assert", 64'(rc_a), 64'(8'd0));

        // Random requests and occasional master resets.
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0);
        end

        // Saturation of the request counter.
        tick(1'b1, 1'b0);
        for (int p = 0; p < 300; p++) begin
            repeat (5) tick(1'b0, 1'b0);
            tick(1'b0, 1'b1);
            if (p == 253) check("a_rc_254", 64'(rc_a), 64'(8'd254));
            if (p == 254) check("a_rc_255", 64'(rc_a), 64'(8'd255));
        end
        check("a_rc_sat", 64'(rc_a), 64'(8'd255));
        check("b_rc_sat", 64'(rc_b), 64'(8'd255));
        check("c_rc_sat", 64'(rc_c), 64'(8'd255));

        // Long quiet run: the unlimited instance never finishes.
        repeat (300) tick(1'b0, 1'b0);
        check("c_done_nolimit", 64'(done_c), 64'(1'b0));
        check("a_done_long",    64'(done_a), 64'(1'b1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
